// File: rtl/lpc_frame_sequencer_pkg.sv
// Shared definitions for the LPC frame sequencer: state encoding, memory-owner
// code for the external port, and parameter defaults.
package lpc_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } seqState_t;

  localparam logic [2:0] MEM_OWNER_EXT = 3'd4;

  localparam int DEFAULT_TIMEOUT_CYCLES = 4095;
  localparam int DEFAULT_NUM_STAGES     = 4;

endpackage

// File: rtl/lpc_frame_sequencer_if.sv
// Control bus between the frame host / datapath blocks and the sequencer.
interface lpc_frame_sequencer_if
  import lpc_frame_sequencer_pkg::*;
  #(parameter int NUM_STAGES = DEFAULT_NUM_STAGES);

  logic                  frameStart;
  logic                  abort;
  logic [NUM_STAGES-1:0] stageEnable;
  logic [NUM_STAGES-1:0] stageDone;
  logic [NUM_STAGES-1:0] stageStart;
  logic [2:0]            memMuxSel;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [7:0]            frameCount;

  modport master (
    output frameStart, abort, stageEnable, stageDone,
    input  stageStart, memMuxSel, busy, done, error, frameCount
  );

  modport slave (
    input  frameStart, abort, stageEnable, stageDone,
    output stageStart, memMuxSel, busy, done, error, frameCount
  );

endinterface

// File: rtl/lpc_frame_sequencer_stage_watchdog.sv
// Saturating per-stage watchdog. The expired flag means the count has reached
// the last cycle before the limit, so the cycle that reaches the limit faults.
module stage_watchdog
  import lpc_frame_sequencer_pkg::*;
  #(parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES)
  (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
  );

  localparam int WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(TIMEOUT_CYCLES - 1);

  logic [WIDTH-1:0] count;

  // Counts enabled cycles and holds at the limit instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign expired = (count >= LAST);

endmodule

// File: rtl/lpc_frame_sequencer.sv
// Sequences the enabled LPC analysis stages for one frame, with a per-stage
// watchdog, abort handling and a completed-frame counter.
module lpc_frame_sequencer
  import lpc_frame_sequencer_pkg::*;
  #(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int NUM_STAGES     = DEFAULT_NUM_STAGES
  )
  (
    input logic                 clk,
    input logic                 reset,
    lpc_frame_sequencer_if.slave bus
  );

  seqState_t             state, nextState;
  logic [2:0]            stage, nextStage;
  logic [NUM_STAGES-1:0] maskQ, nextMask, stageOneHot;
  logic [3:0]            pick;
  logic                  wdClear, wdEnable, wdExpired;

  logic [NUM_STAGES-1:0] stageStartQ;
  logic [2:0]            memMuxSelQ;
  logic                  busyQ, doneQ, errorQ;
  logic [7:0]            frameCountQ;

  // Returns {found, index} of the lowest enabled stage at or above fromIdx.
  function automatic logic [3:0] firstEnabled(input logic [NUM_STAGES-1:0] mask,
                                              input logic [2:0] fromIdx);
    firstEnabled = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(fromIdx))) firstEnabled = {1'b1, 3'(i)};
    end
  endfunction

  assign stageOneHot = NUM_STAGES'(1) << stage;

  stage_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wdClear),
    .enable  (wdEnable),
    .expired (wdExpired)
  );

  // Next-state logic; only the active stage's done bit is observed.
  always_comb begin
    nextState = state;
    nextStage = stage;
    nextMask  = maskQ;
    wdClear   = 1'b0;
    wdEnable  = 1'b0;
    pick      = '0;
    case (state)
      IDLE: begin
        if (bus.frameStart) begin
          nextMask = bus.stageEnable;
          pick     = firstEnabled(bus.stageEnable, 3'd0);
          if (pick[3]) begin
            nextStage = pick[2:0];
            nextState = START;
          end else begin
            nextState = DONE;
          end
        end
      end
      START: begin
        wdClear   = 1'b1;
        nextState = bus.abort ? IDLE : WAIT;
      end
      WAIT: begin
        if (bus.abort) begin
          nextState = IDLE;
        end else begin
          wdEnable = 1'b1;
          // A done arriving on the timeout cycle still advances the frame.
          if (|(bus.stageDone & stageOneHot)) begin
            pick = firstEnabled(maskQ, stage + 3'd1);
            if (pick[3]) begin
              nextStage = pick[2:0];
              nextState = START;
            end else begin
              nextState = DONE;
            end
          end else if (wdExpired) begin
            nextState = ERR;
          end
        end
      end
      DONE: nextState = IDLE;
      ERR:  if (bus.abort) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State and output registers; outputs follow the state being entered,
  // except done/frameCount which fire as DONE is left without an abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      stage       <= 3'd0;
      maskQ       <= '0;
      stageStartQ <= '0;
      memMuxSelQ  <= MEM_OWNER_EXT;
      busyQ       <= 1'b0;
      doneQ       <= 1'b0;
      errorQ      <= 1'b0;
      frameCountQ <= 8'd0;
    end else begin
      state       <= nextState;
      stage       <= nextStage;
      maskQ       <= nextMask;
      stageStartQ <= (nextState == START) ? (NUM_STAGES'(1) << nextStage) : '0;
      memMuxSelQ  <= ((nextState == START) || (nextState == WAIT)) ? nextStage : MEM_OWNER_EXT;
      busyQ       <= (nextState == START) || (nextState == WAIT) || (nextState == DONE);
      errorQ      <= (nextState == ERR);
      doneQ       <= (state == DONE) && !bus.abort;
      if ((state == DONE) && !bus.abort) frameCountQ <= frameCountQ + 8'd1;
    end
  end

  assign bus.stageStart = stageStartQ;
  assign bus.memMuxSel  = memMuxSelQ;
  assign bus.busy       = busyQ;
  assign bus.done       = doneQ;
  assign bus.error      = errorQ;
  assign bus.frameCount = frameCountQ;

endmodule
